dma_r_burst_ctrl: RTL and testbench



---
 rtl/dma_r_burst_ctrl_if.sv | 30 +++
 rtl/dma_r_burst_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dma_r_burst_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_r_burst_ctrl_if.sv
// Purpose : burst request / beat return bus between the burst splitter and the AXI read engine.
// Latency : wires only; no storage.
// Backpressure : none on beats; bursts are only requested when the engine reports dma_ready.
// Ports   : eng_valid/eng_addr/eng_len (burst request), eng_ready/eng_rdata (beat strobe + data),
//           eng_dma_ready (engine idle in address phase), eng_error (rlast mismatch, per burst).
interface dma_r_burst_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 32
);
  logic              eng_valid;
  logic [ADDR_W-1:0] eng_addr;
  logic [LEN_W-1:0]  eng_len;
  logic              eng_ready;
  logic [DATA_W-1:0] eng_rdata;
  logic              eng_dma_ready;
  logic              eng_error;

  // Burst splitter side.
  modport master (
    output eng_valid, eng_addr, eng_len,
    input  eng_ready, eng_rdata, eng_dma_ready, eng_error
  );

  // Read engine side.
  modport slave (
    input  eng_valid, eng_addr, eng_len,
    output eng_ready, eng_rdata, eng_dma_ready, eng_error
  );
endinterface

// File: rtl/dma_r_burst_ctrl.sv
// Purpose : splits one read command into AXI4 INCR bursts (<= MAX_BEATS, never crossing 4 KB),
//           forwards returned beats with a transfer-level last flag, reports done / sticky error.
// Latency : start -> first eng_valid 2 cycles; last beat of burst -> next eng_valid 3 cycles;
//           last beat of transfer -> done next cycle. Beats pass through combinationally.
// Backpressure : none downstream; a burst is only requested when out_free covers all its beats.
// Ports   : clk/rst, command (start, start_addr, word_cnt), status (busy, done, error),
//           out_free credit, engine bus (interface), output beat stream (m_valid, m_data, m_last).
module dma_r_burst_ctrl #(
  parameter int DMA_DATA_W = 32,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 24,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [CNT_W-1:0]      word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [LEN_W:0]        out_free,
  dma_r_burst_ctrl_if.master    bus,
  output logic                  m_valid,
  output logic [DMA_DATA_W-1:0] m_data,
  output logic                  m_last
);

  localparam int BPB = DMA_DATA_W / 8;
  localparam int OFS = $clog2(BPB);
  // Common width for the three-way minimum (remaining vs. 13-bit 4 KB distance).
  localparam int MW  = (CNT_W > 13) ? CNT_W : 13;
  localparam logic [LEN_W:0]    BEAT_ONE   = 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BPB - 1);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, DATA, CHECK} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [LEN_W:0]    burst_beats_q;
  logic [LEN_W:0]    beat_cnt_q;
  logic              error_q;
  logic              zero_done_q;
  logic              eng_valid_q;
  logic [ADDR_W-1:0] eng_addr_q;
  logic [LEN_W-1:0]  eng_len_q;

  logic [12:0]       b4k;
  logic [MW-1:0]     lim;
  logic [LEN_W:0]    calc_beats;
  logic              credit_ok_calc;
  logic              credit_ok;
  logic              beat;
  logic              last_of_burst;
  logic              done_chk;

  // Beats left before the next 4 KB boundary.
  assign b4k = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> OFS;

  always_comb begin
    lim = MW'(MAX_BEATS);
    if (MW'(remaining_q) < lim) lim = MW'(remaining_q);
    if (MW'(b4k) < lim)         lim = MW'(b4k);
    calc_beats = (LEN_W + 1)'(lim);
  end

  // Credit is checked in CALC against the freshly computed size so eng_valid can rise on
  // the first ISSUE cycle; in ISSUE it is rechecked against the registered size.
  assign credit_ok_calc = (out_free >= calc_beats) && bus.eng_dma_ready;
  assign credit_ok      = (out_free >= burst_beats_q) && bus.eng_dma_ready;

  // The first beat lands while still in ISSUE (it doubles as the request accept).
  assign beat          = bus.eng_ready &&
                         ((state_q == DATA) || ((state_q == ISSUE) && eng_valid_q));
  assign last_of_burst = beat && ((beat_cnt_q + BEAT_ONE) == burst_beats_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    done_chk = 1'b0;
    case (state_q)
      IDLE:  if (start && (word_cnt != '0)) state_d = CALC;
      CALC:  state_d = ISSUE;
      ISSUE: if (beat) state_d = last_of_burst ? CHECK : DATA;
      DATA:  if (last_of_burst) state_d = CHECK;
      CHECK: begin
        if (bus.eng_error || (remaining_q == '0)) begin
          state_d  = IDLE;
          done_chk = 1'b1;
        end else begin
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      burst_beats_q <= '0;
      beat_cnt_q    <= '0;
      error_q       <= 1'b0;
      zero_done_q   <= 1'b0;
      eng_valid_q   <= 1'b0;
      eng_addr_q    <= '0;
      eng_len_q     <= '0;
    end else begin
      zero_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            error_q <= 1'b0;
            if (word_cnt == '0) begin
              zero_done_q <= 1'b1;
            end else begin
              cur_addr_q  <= start_addr & ALIGN_MASK;
              remaining_q <= word_cnt;
            end
          end
        end
        CALC: begin
          burst_beats_q <= calc_beats;
          beat_cnt_q    <= '0;
          if (credit_ok_calc) begin
            eng_valid_q <= 1'b1;
            eng_addr_q  <= cur_addr_q;
            eng_len_q   <= LEN_W'(calc_beats - BEAT_ONE);
          end
        end
        ISSUE: begin
          if (eng_valid_q) begin
            if (bus.eng_ready) eng_valid_q <= 1'b0;
          end else if (credit_ok) begin
            eng_valid_q <= 1'b1;
            eng_addr_q  <= cur_addr_q;
            eng_len_q   <= LEN_W'(burst_beats_q - BEAT_ONE);
          end
        end
        CHECK: if (bus.eng_error) error_q <= 1'b1;
        default: ;
      endcase
      if (beat) begin
        beat_cnt_q  <= beat_cnt_q + BEAT_ONE;
        remaining_q <= remaining_q - CNT_W'(1);
        if (last_of_burst) cur_addr_q <= cur_addr_q + (ADDR_W'(burst_beats_q) << OFS);
      end
    end
  end

  assign bus.eng_valid = eng_valid_q;
  assign bus.eng_addr  = eng_addr_q;
  assign bus.eng_len   = eng_len_q;

  assign busy    = (state_q != IDLE);
  assign done    = zero_done_q | done_chk;
  assign error   = error_q;
  assign m_valid = beat;
  assign m_data  = bus.eng_rdata;
  assign m_last  = beat && (remaining_q == CNT_W'(1));

endmodule

// File: tb/tb_dma_r_burst_ctrl.sv
// Purpose : scoreboard bench for dma_r_burst_ctrl with a behavioural read-engine model.
// Latency : engine answers a burst request in the cycle it sees eng_valid; one stall at beat 3.
// Backpressure : credit via out_free only; the bench never stalls the output stream.
module tb_dma_r_burst_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [23:0] word_cnt = '0;
  logic        busy, done, error;
  logic [8:0]  out_free = 9'd16;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;

  dma_r_burst_ctrl_if #(.ADDR_W(32), .LEN_W(8), .DATA_W(32)) bus ();

  dma_r_burst_ctrl #(
    .DMA_DATA_W(32), .ADDR_W(32), .LEN_W(8), .CNT_W(24), .MAX_BEATS(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .error(error), .out_free(out_free), .bus(bus),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // Expectation queues.
  logic [31:0] exp_baddr[$];
  logic [7:0]  exp_blen[$];
  logic [32:0] exp_beat[$];     // {last, data}
  logic        exp_done_err[$];
  string       chk_nm[$];
  logic [63:0] chk_act[$];
  logic [63:0] chk_exp[$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int beat_seen = 0;
  int burst_total = 0;
  int err_target = -1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_nm.push_back(nm);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  task automatic push_burst(input logic [31:0] a, input logic [7:0] l);
    exp_baddr.push_back(a);
    exp_blen.push_back(l);
  endtask

  task automatic push_beats(input logic [31:0] a, input int n, input int total);
    for (int k = 0; k < n; k++) exp_beat.push_back({(k == total - 1), a + 32'(4 * k)});
  endtask

  task automatic cmd(input logic [31:0] a, input logic [23:0] n);
    @(posedge clk); #1;
    start_addr = a;
    word_cnt   = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int i;
    i = 0;
    while (done_cnt < target && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    if (done_cnt < target) check(nm, 64'(done_cnt), 64'(target));
  endtask

  // Read engine model: takes the request, returns len+1 beats whose data is the beat address.
  initial begin : engine
    logic [31:0] a;
    int n;
    bus.eng_ready = 1'b0;
    bus.eng_rdata = '0;
    bus.eng_dma_ready = 1'b1;
    bus.eng_error = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.eng_valid === 1'b1) begin
        a = bus.eng_addr;
        n = int'(bus.eng_len) + 1;
        bus.eng_dma_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
          if (i == 3) begin
            bus.eng_ready = 1'b0;
            @(posedge clk); #1;
          end
          bus.eng_ready = 1'b1;
          bus.eng_rdata = a + 32'(4 * i);
          if (i == n - 1) begin
            bus.eng_error = (burst_total == err_target);
            burst_total++;
          end
          @(posedge clk); #1;
        end
        bus.eng_ready = 1'b0;
        bus.eng_dma_ready = 1'b1;
      end
    end
  end

  // Monitor: drains direct checks and compares every DUT output event against the queues.
  initial begin : monitor
    logic        prev_v;
    logic        err_pending;
    logic        err_want;
    string       nm;
    logic [63:0] a, e;
    logic [31:0] ea;
    logic [7:0]  el;
    logic [32:0] eb;
    prev_v = 1'b0;
    err_pending = 1'b0;
    err_want = 1'b0;
    forever begin
      @(negedge clk);
      while (chk_nm.size() > 0) begin
        nm = chk_nm.pop_front();
        a  = chk_act.pop_front();
        e  = chk_exp.pop_front();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got %0h, required %0h", nm, a, e);
        end
      end
      if (err_pending) begin
        n_cmp++;
        if (error !== err_want) begin
          n_bad++;
          $display("FAIL error_after_done: got %0b, required %0b", error, err_want);
        end
        err_pending = 1'b0;
      end
      if (!rst) begin
        if (bus.eng_valid && !prev_v) begin
          n_cmp++;
          if (exp_baddr.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_burst: got addr %0h len %0d, required no request",
                     bus.eng_addr, bus.eng_len);
          end else begin
            ea = exp_baddr.pop_front();
            el = exp_blen.pop_front();
            if (bus.eng_addr !== ea || bus.eng_len !== el) begin
              n_bad++;
              $display("FAIL burst: got addr %0h len %0d, required addr %0h len %0d",
                       bus.eng_addr, bus.eng_len, ea, el);
            end
          end
        end
        if (m_valid) begin
          beat_seen++;
          n_cmp++;
          if (exp_beat.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: got data %0h last %0b, required none", m_data, m_last);
          end else begin
            eb = exp_beat.pop_front();
            if ({m_last, m_data} !== eb) begin
              n_bad++;
              $display("FAIL beat: got data %0h last %0b, required data %0h last %0b",
                       m_data, m_last, eb[31:0], eb[32]);
            end
          end
        end
        if (done) begin
          done_cnt++;
          n_cmp++;
          if (exp_done_err.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_done: got done 1, required 0");
          end else begin
            err_want = exp_done_err.pop_front();
            err_pending = 1'b1;
          end
        end
      end
      prev_v = bus.eng_valid;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_eng_valid"}, 64'(bus.eng_valid), 0);
    check({tag, "_eng_addr"},  64'(bus.eng_addr), 0);
    check({tag, "_eng_len"},   64'(bus.eng_len), 0);
    check({tag, "_busy"},      64'(busy), 0);
    check({tag, "_done"},      64'(done), 0);
    check({tag, "_error"},     64'(error), 0);
    check({tag, "_m_valid"},   64'(m_valid), 0);
    check({tag, "_m_last"},    64'(m_last), 0);
  endtask

  initial begin : stim
    int base;
    int i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Multi-burst split.
    push_burst(32'h1000, 8'd15);
    push_burst(32'h1040, 8'd15);
    push_burst(32'h1080, 8'd7);
    push_beats(32'h1000, 40, 40);
    exp_done_err.push_back(1'b0);
    base = done_cnt;
    cmd(32'h1000, 24'd40);
    wait_done(base + 1, 500, "done_multi_timeout");
    check("busy_in_done_cycle", 64'(busy), 1);
    @(negedge clk);
    check("busy_after_done", 64'(busy), 0);

    // 4 KB crossing.
    push_burst(32'h1FF8, 8'd1);
    push_burst(32'h2000, 8'd5);
    push_beats(32'h1FF8, 8, 8);
    exp_done_err.push_back(1'b0);
    base = done_cnt;
    cmd(32'h1FF8, 24'd8);
    wait_done(base + 1, 200, "done_4k_timeout");
    repeat (3) @(posedge clk);

    // Zero length.
    exp_done_err.push_back(1'b0);
    cmd(32'h1234, 24'd0);
    @(negedge clk);
    check("zero_done_c1", 64'(done), 1);
    check("zero_busy_c1", 64'(busy), 0);
    @(negedge clk);
    check("zero_done_c2", 64'(done), 0);
    check("zero_busy_c2", 64'(busy), 0);

    // Credit stall.
    out_free = 9'd4;
    push_burst(32'h3000, 8'd15);
    push_beats(32'h3000, 16, 16);
    exp_done_err.push_back(1'b0);
    base = done_cnt;
    cmd(32'h3000, 24'd16);
    repeat (6) @(negedge clk);
    check("stall_valid_low", 64'(bus.eng_valid), 0);
    @(posedge clk); #1;
    out_free = 9'd16;
    @(negedge clk);
    check("stall_valid_same_cycle", 64'(bus.eng_valid), 0);
    @(negedge clk);
    check("stall_valid_next_cycle", 64'(bus.eng_valid), 1);
    wait_done(base + 1, 200, "done_stall_timeout");

    // Engine error on the first of three bursts.
    err_target = burst_total;
    push_burst(32'h4000, 8'd15);
    push_beats(32'h4000, 16, 40);
    exp_done_err.push_back(1'b1);
    base = done_cnt;
    cmd(32'h4000, 24'd40);
    wait_done(base + 1, 300, "done_err_timeout");
    repeat (8) @(negedge clk);
    check("error_sticky", 64'(error), 1);
    check("busy_after_err", 64'(busy), 0);
    err_target = -1;
    push_burst(32'h5000, 8'd3);
    push_beats(32'h5000, 4, 4);
    exp_done_err.push_back(1'b0);
    base = done_cnt;
    cmd(32'h5000, 24'd4);
    @(negedge clk);
    check("error_cleared", 64'(error), 0);
    wait_done(base + 1, 200, "done_after_err_timeout");

    // Reset during the second burst.
    push_burst(32'h6000, 8'd15);
    push_burst(32'h6040, 8'd15);
    push_beats(32'h6000, 40, 40);
    base = beat_seen;
    cmd(32'h6000, 24'd40);
    i = 0;
    while (beat_seen < base + 20 && i < 300) begin
      @(negedge clk); #1;
      i++;
    end
    if (beat_seen < base + 20) check("beats_before_reset_timeout", 64'(beat_seen), 64'(base + 20));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_baddr.delete();
    exp_blen.delete();
    exp_beat.delete();
    exp_done_err.delete();
    @(negedge clk);
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    i = 0;
    while (bus.eng_dma_ready !== 1'b1 && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    if (bus.eng_dma_ready !== 1'b1) check("engine_idle_timeout", 64'(bus.eng_dma_ready), 1);
    repeat (2) @(posedge clk);
    push_burst(32'h7000, 8'd3);
    push_beats(32'h7000, 4, 4);
    exp_done_err.push_back(1'b0);
    base = done_cnt;
    cmd(32'h7000, 24'd4);
    wait_done(base + 1, 200, "done_post_reset_timeout");

    repeat (5) @(negedge clk);
    check("left_bursts", 64'(exp_baddr.size()), 0);
    check("left_beats",  64'(exp_beat.size()), 0);
    check("left_dones",  64'(exp_done_err.size()), 0);
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
